// File: rtl/execute_stage_pkg.sv
// Shared encodings and types for the execute stage.
// Holds ALU, branch, divide and forwarding selects plus the EX/MEM bundle.
package execute_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'b00,
        DIV_DIVU = 2'b01,
        DIV_REM  = 2'b10,
        DIV_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memwrite;
        logic [1:0]  resultsrc;
    } ex_mem_t;

    // Select 11 deliberately falls back to the register value.
    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] r,
        input logic [31:0] w,
        input logic [31:0] m
    );
        logic [31:0] v;
        v = r;
        case (sel)
            FWD_W:   v = w;
            FWD_M:   v = m;
            default: v = r;
        endcase
        return v;
    endfunction

    function automatic logic br_taken(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQ:  t = (a == b);
            BR_BNE:  t = (a != b);
            BR_BLT:  t = ($signed(a) < $signed(b));
            BR_BGE:  t = ($signed(a) >= $signed(b));
            BR_BLTU: t = (a < b);
            BR_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/iter_divider.sv
// Iterative restoring divider: 32 cycles busy, one cycle done.
// Operands are captured at start so upstream forwarding can change freely.
module iter_divider
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state;
    div_state_e  state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic [31:0] dvnd;
    logic        rem_q;
    logic        neg_q;
    logic        neg_r;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [32:0] sh;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign sgn   = (op == DIV_DIV) || (op == DIV_REM);
    assign a_neg = sgn & a[31];
    assign b_neg = sgn & b[31];
    assign sh    = {rem, quo[31]};
    assign diff  = sh - {1'b0, dvsr};

    always_ff @(posedge clk) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE: if (start) state_nxt = DIV_BUSY;
            DIV_BUSY: if (cnt == 5'd31) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            dvnd  <= '0;
            rem_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt   <= '0;
            quo   <= a_neg ? -a : a;
            rem   <= '0;
            dvsr  <= b_neg ? -b : b;
            dvnd  <= a;
            rem_q <= op[1];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 5'd1;
            if (!diff[32]) begin
                rem <= diff[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= sh[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    // Divide by zero overrides the sign fix-up on both results.
    always_comb begin
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
        if (dvsr == 32'd0) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = dvnd;
        end
    end

    assign result = rem_q ? r_fix : q_fix;
    assign busy   = (state == DIV_BUSY);
    assign done   = (state == DIV_DONE);

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding, ALU, branch resolve, divider and EX/MEM register.
// A divide stalls upstream until its result is written into EX/MEM.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  rdE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ALUSrcE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        JalrE,
    input  logic [1:0]  ResultSrcE,
    input  logic [3:0]  ALUControlE,
    input  logic [2:0]  BranchOpE,
    input  logic        DivE,
    input  logic [1:0]  DivOpE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCsrcE,
    output logic [31:0] PCTargetE,
    output logic        stallE,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  rdM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM
);

    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] wdata;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] jalr_sum;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_res;
    ex_mem_t     ex_mem_q;

    assign srca  = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    assign wdata = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
    assign srcb  = ALUSrcE ? ImmExtE : wdata;
    assign shamt = srcb[4:0];

    always_comb begin
        alu_res = '0;
        unique case (alu_op_e'(ALUControlE))
            ALU_ADD:  alu_res = srca + srcb;
            ALU_SUB:  alu_res = srca - srcb;
            ALU_AND:  alu_res = srca & srcb;
            ALU_OR:   alu_res = srca | srcb;
            ALU_XOR:  alu_res = srca ^ srcb;
            ALU_SLL:  alu_res = srca << shamt;
            ALU_SRL:  alu_res = srca >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(srca) >>> shamt);
            ALU_SLT:  alu_res = {31'd0, $signed(srca) < $signed(srcb)};
            ALU_SLTU: alu_res = {31'd0, srca < srcb};
            default:  alu_res = '0;
        endcase
    end

    // Only an idle divider may accept a new divide.
    assign div_start = DivE & ~div_busy & ~div_done;
    assign stallE    = div_busy | div_start;

    iter_divider u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start),
        .op     (DivOpE),
        .a      (srca),
        .b      (srcb),
        .busy   (div_busy),
        .done   (div_done),
        .result (div_res)
    );

    assign jalr_sum  = srca + ImmExtE;
    assign PCTargetE = JalrE ? {jalr_sum[31:1], 1'b0} : PCE + ImmExtE;
    assign PCsrcE    = ~stallE &
                       (JumpE | (BranchE & br_taken(BranchOpE, srca, wdata)));

    always_ff @(posedge clk) begin
        if (!rst || stallE) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q.alu_res   <= div_done ? div_res : alu_res;
            ex_mem_q.wdata     <= wdata;
            ex_mem_q.pc4       <= PCPlus4E;
            ex_mem_q.rd        <= rdE;
            ex_mem_q.regwrite  <= RegWriteE;
            ex_mem_q.memwrite  <= MemWriteE;
            ex_mem_q.resultsrc <= ResultSrcE;
        end
    end

    assign ALUResultM = ex_mem_q.alu_res;
    assign WriteDataM = ex_mem_q.wdata;
    assign PCPlus4M   = ex_mem_q.pc4;
    assign rdM        = ex_mem_q.rd;
    assign RegWriteM  = ex_mem_q.regwrite;
    assign MemWriteM  = ex_mem_q.memwrite;
    assign ResultSrcM = ex_mem_q.resultsrc;

endmodule
